// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a register-array SRAM: INCR bursts, full 64-bit beats.
// Optional start-address range check (DECERR) enabled by defining AXI_SRAM_DECERR_EN.
module axi_sram_responder #(
   parameter int unsigned          IdWidth   = 4,
   parameter int unsigned          AddrWidth = 64,
   parameter int unsigned          DataWidth = 64,
   parameter int unsigned          Depth     = 1024,
   parameter logic [AddrWidth-1:0] BaseAddr  = 64'h8000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   aw_valid_i,
   output logic                   aw_ready_o,
   input  logic [IdWidth-1:0]     aw_id_i,
   input  logic [AddrWidth-1:0]   aw_addr_i,
   input  logic [7:0]             aw_len_i,
   input  logic                   w_valid_i,
   output logic                   w_ready_o,
   input  logic [DataWidth-1:0]   w_data_i,
   input  logic [DataWidth/8-1:0] w_strb_i,
   input  logic                   w_last_i,
   output logic                   b_valid_o,
   input  logic                   b_ready_i,
   output logic [IdWidth-1:0]     b_id_o,
   output logic [1:0]             b_resp_o,
   input  logic                   ar_valid_i,
   output logic                   ar_ready_o,
   input  logic [IdWidth-1:0]     ar_id_i,
   input  logic [AddrWidth-1:0]   ar_addr_i,
   input  logic [7:0]             ar_len_i,
   output logic                   r_valid_o,
   input  logic                   r_ready_i,
   output logic [IdWidth-1:0]     r_id_o,
   output logic [DataWidth-1:0]   r_data_o,
   output logic [1:0]             r_resp_o,
   output logic                   r_last_o
);

   localparam int unsigned IdxW      = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic {RIdle, RData} r_state_e;

   function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] addr);
      logic [AddrWidth-1:0] word;
      word = (addr - BaseAddr) >> 3;
      word = word % AddrWidth'(Depth);
      return word[IdxW-1:0];
   endfunction

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
      return (idx == IdxW'(Depth - 1)) ? '0 : idx + IdxW'(1);
   endfunction

   logic [DataWidth-1:0] mem_q [Depth];

   logic aw_dec, ar_dec;
`ifdef AXI_SRAM_DECERR_EN
   function automatic logic in_range(input logic [AddrWidth-1:0] addr);
      logic [AddrWidth-1:0] off;
      off = addr - BaseAddr;
      return (addr >= BaseAddr) && (off < (AddrWidth'(Depth) << 3));
   endfunction

   assign aw_dec = !in_range(aw_addr_i);
   assign ar_dec = !in_range(ar_addr_i);
`else
   assign aw_dec = 1'b0;
   assign ar_dec = 1'b0;
`endif

   // ---------------- write path ----------------
   w_state_e          w_state_q, w_state_d;
   logic [IdWidth-1:0] w_id_q, w_id_d;
   logic [IdxW-1:0]    w_idx_q, w_idx_d;
   logic [7:0]         w_len_q, w_len_d;
   logic [7:0]         w_cnt_q, w_cnt_d;
   logic               w_err_q, w_err_d;
   logic               w_dec_q, w_dec_d;
   logic               mem_we;

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      w_dec_d   = w_dec_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (aw_valid_i) begin
               w_id_d    = aw_id_i;
               w_idx_d   = word_idx(aw_addr_i);
               w_len_d   = aw_len_i;
               w_cnt_d   = '0;
               w_err_d   = 1'b0;
               w_dec_d   = aw_dec;
               w_state_d = WData;
            end
         end
         WData: begin
            if (w_valid_i) begin
               mem_we  = !w_dec_q && !rst_i;
               // Burst length follows len; a misplaced w_last only flags SLVERR.
               if (w_last_i != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
               w_idx_d = next_idx(w_idx_q);
               w_cnt_d = w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) w_state_d = WResp;
            end
         end
         WResp: begin
            if (b_ready_i) w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= WIdle;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         w_dec_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         w_dec_q   <= w_dec_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (w_strb_i[b]) mem_q[w_idx_q][8*b +: 8] <= w_data_i[8*b +: 8];
         end
      end
   end

   assign aw_ready_o = !rst_i && (w_state_q == WIdle);
   assign w_ready_o  = !rst_i && (w_state_q == WData);
   assign b_valid_o  = !rst_i && (w_state_q == WResp);
   assign b_id_o     = rst_i ? '0 : w_id_q;
   assign b_resp_o   = rst_i   ? 2'b00 :
                       w_dec_q ? 2'b11 :
                       w_err_q ? 2'b10 : 2'b00;

   // ---------------- read path ----------------
   r_state_e           r_state_q, r_state_d;
   logic [IdWidth-1:0]   r_id_q, r_id_d;
   logic [IdxW-1:0]      r_idx_q, r_idx_d;
   logic [7:0]           r_len_q, r_len_d;
   logic [7:0]           r_cnt_q, r_cnt_d;
   logic                 r_dec_q, r_dec_d;
   logic [DataWidth-1:0] r_data_q, r_data_d;
   logic [IdxW-1:0]      ar_idx;

   assign ar_idx = word_idx(ar_addr_i);

   // r_idx_q points at the word to load for the next beat; mem_q reads see
   // pre-write contents when a write lands on the same edge.
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_dec_d   = r_dec_q;
      r_data_d  = r_data_q;
      unique case (r_state_q)
         RIdle: begin
            if (ar_valid_i) begin
               r_id_d    = ar_id_i;
               r_len_d   = ar_len_i;
               r_cnt_d   = '0;
               r_dec_d   = ar_dec;
               r_data_d  = ar_dec ? '0 : mem_q[ar_idx];
               r_idx_d   = next_idx(ar_idx);
               r_state_d = RData;
            end
         end
         RData: begin
            if (r_ready_i) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = RIdle;
               end else begin
                  r_data_d = r_dec_q ? '0 : mem_q[r_idx_q];
                  r_idx_d  = next_idx(r_idx_q);
                  r_cnt_d  = r_cnt_q + 8'd1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q <= RIdle;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_dec_q   <= 1'b0;
         r_data_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_dec_q   <= r_dec_d;
         r_data_q  <= r_data_d;
      end
   end

   assign ar_ready_o = !rst_i && (r_state_q == RIdle);
   assign r_valid_o  = !rst_i && (r_state_q == RData);
   assign r_id_o     = rst_i ? '0 : r_id_q;
   assign r_data_o   = rst_i ? '0 : r_data_q;
   assign r_resp_o   = (!rst_i && r_dec_q) ? 2'b11 : 2'b00;
   assign r_last_o   = r_valid_o && (r_cnt_q == r_len_q);

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder; expectations follow AXI_SRAM_DECERR_EN if defined.
module tb_axi_sram_responder;

   localparam int unsigned Depth = 1024;
   localparam logic [63:0] Base  = 64'h8000_0000;
`ifdef AXI_SRAM_DECERR_EN
   localparam logic [1:0] OorResp = 2'b11;
`else
   localparam logic [1:0] OorResp = 2'b00;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        aw_valid_i = 1'b0, aw_ready_o;
   logic [3:0]  aw_id_i = '0;
   logic [63:0] aw_addr_i = '0;
   logic [7:0]  aw_len_i = '0;
   logic        w_valid_i = 1'b0, w_ready_o;
   logic [63:0] w_data_i = '0;
   logic [7:0]  w_strb_i = '0;
   logic        w_last_i = 1'b0;
   logic        b_valid_o, b_ready_i = 1'b0;
   logic [3:0]  b_id_o;
   logic [1:0]  b_resp_o;
   logic        ar_valid_i = 1'b0, ar_ready_o;
   logic [3:0]  ar_id_i = '0;
   logic [63:0] ar_addr_i = '0;
   logic [7:0]  ar_len_i = '0;
   logic        r_valid_o, r_ready_i = 1'b0;
   logic [3:0]  r_id_o;
   logic [63:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        r_last_o;

   always #5 clk_i = ~clk_i;

   axi_sram_responder dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .aw_valid_i (aw_valid_i),
      .aw_ready_o (aw_ready_o),
      .aw_id_i    (aw_id_i),
      .aw_addr_i  (aw_addr_i),
      .aw_len_i   (aw_len_i),
      .w_valid_i  (w_valid_i),
      .w_ready_o  (w_ready_o),
      .w_data_i   (w_data_i),
      .w_strb_i   (w_strb_i),
      .w_last_i   (w_last_i),
      .b_valid_o  (b_valid_o),
      .b_ready_i  (b_ready_i),
      .b_id_o     (b_id_o),
      .b_resp_o   (b_resp_o),
      .ar_valid_i (ar_valid_i),
      .ar_ready_o (ar_ready_o),
      .ar_id_i    (ar_id_i),
      .ar_addr_i  (ar_addr_i),
      .ar_len_i   (ar_len_i),
      .r_valid_o  (r_valid_o),
      .r_ready_i  (r_ready_i),
      .r_id_o     (r_id_o),
      .r_data_o   (r_data_o),
      .r_resp_o   (r_resp_o),
      .r_last_o   (r_last_o)
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   r_exp_t      r_q[$];
   b_exp_t      b_q[$];
   logic [63:0] model [Depth];
   logic [63:0] wd [4];
   int          n_vec  = 0;
   int          n_miss = 0;

   function automatic logic [9:0] widx(input logic [63:0] addr);
      logic [63:0] w;
      w = (addr - Base) >> 3;
      return w[9:0];
   endfunction

   task automatic ar_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
      int t = 0;
      ar_valid_i = 1'b1;
      ar_id_i    = id;
      ar_addr_i  = addr;
      ar_len_i   = len;
      @(negedge clk_i);
      while (!ar_ready_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      n_vec++;
      if (ar_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL ar_handshake ar_ready=%b want 1", ar_ready_o);
      end
      @(posedge clk_i);
      #1 ar_valid_i = 1'b0;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
      int t = 0;
      aw_valid_i = 1'b1;
      aw_id_i    = id;
      aw_addr_i  = addr;
      aw_len_i   = len;
      @(negedge clk_i);
      while (!aw_ready_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      n_vec++;
      if (aw_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL aw_handshake aw_ready=%b want 1", aw_ready_o);
      end
      @(posedge clk_i);
      #1 aw_valid_i = 1'b0;
   endtask

   task automatic b_collect();
      int     t = 0;
      b_exp_t e;
      b_ready_i = 1'b0;
      @(negedge clk_i);
      while (!b_valid_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      e = b_q.pop_front();
      n_vec++;
      if (b_valid_o !== 1'b1 || b_id_o !== e.id || b_resp_o !== e.resp) begin
         n_miss++;
         $display("FAIL b_resp valid=%b id=%h resp=%b want valid=1 id=%h resp=%b",
                  b_valid_o, b_id_o, b_resp_o, e.id, e.resp);
      end
      @(negedge clk_i);
      n_vec++;
      if (b_valid_o !== 1'b1 || b_id_o !== e.id || b_resp_o !== e.resp) begin
         n_miss++;
         $display("FAIL b_hold valid=%b id=%h resp=%b want valid=1 id=%h resp=%b",
                  b_valid_o, b_id_o, b_resp_o, e.id, e.resp);
      end
      b_ready_i = 1'b1;
      @(posedge clk_i);
      #1 b_ready_i = 1'b0;
      @(negedge clk_i);
      n_vec++;
      if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL b_done b_valid=%b aw_ready=%b want 0 1", b_valid_o, aw_ready_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   // Beats come from wd[]; w_last is raised only on beat last_beat.
   task automatic write_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [7:0] strb, input int last_beat,
                              input logic [1:0] exp_resp);
      logic [9:0] i = widx(addr);
      b_exp_t     e;
      int         t;
      aw_send(id, addr, len);
      for (int b = 0; b <= int'(len); b++) begin
         w_valid_i = 1'b1;
         w_data_i  = wd[b];
         w_strb_i  = strb;
         w_last_i  = (b == last_beat);
         t = 0;
         @(negedge clk_i);
         while (!w_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
         end
         n_vec++;
         if (w_ready_o !== 1'b1) begin
            n_miss++;
            $display("FAIL w_beat%0d w_ready=%b want 1", b, w_ready_o);
         end
         @(posedge clk_i);
         #1 w_valid_i = 1'b0;
         if (exp_resp != 2'b11) begin
            for (int k = 0; k < 8; k++) begin
               if (strb[k]) model[i][8*k +: 8] = wd[b][8*k +: 8];
            end
         end
         i = i + 10'd1;
      end
      w_last_i = 1'b0;
      e.id   = id;
      e.resp = exp_resp;
      b_q.push_back(e);
      b_collect();
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input bit toggle, input logic [1:0] exp_resp);
      logic [9:0] i = widx(addr);
      r_exp_t     e, obs, snap;
      int         got = 0;
      int         cyc = 0;
      bit         stalled = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         e.id   = id;
         e.data = (exp_resp == 2'b11) ? 64'h0 : model[i];
         e.resp = exp_resp;
         e.last = (b == int'(len));
         r_q.push_back(e);
         i = i + 10'd1;
      end
      ar_send(id, addr, len);
      while (got <= int'(len) && cyc < 200) begin
         r_ready_i = toggle ? cyc[0] : 1'b1;
         @(negedge clk_i);
         obs = {r_id_o, r_data_o, r_resp_o, r_last_o};
         if (cyc == 0) begin
            n_vec++;
            if (r_valid_o !== 1'b1) begin
               n_miss++;
               $display("FAIL r_first r_valid=%b want 1", r_valid_o);
            end
         end
         if (r_valid_o === 1'b1) begin
            if (stalled) begin
               n_vec++;
               if (obs !== snap) begin
                  n_miss++;
                  $display("FAIL r_stall obs=%h want %h", obs, snap);
               end
            end
            if (r_ready_i) begin
               e = r_q.pop_front();
               n_vec++;
               if (obs !== e) begin
                  n_miss++;
                  $display("FAIL r_beat%0d id=%h data=%h resp=%b last=%b want id=%h data=%h resp=%b last=%b",
                           got, obs.id, obs.data, obs.resp, obs.last, e.id, e.data, e.resp, e.last);
               end
               got++;
               stalled = 1'b0;
            end else begin
               snap    = obs;
               stalled = 1'b1;
            end
         end
         @(posedge clk_i);
         #1;
         cyc++;
      end
      r_ready_i = 1'b0;
      n_vec++;
      if (got != int'(len) + 1) begin
         n_miss++;
         $display("FAIL r_count beats=%0d want %0d", got, int'(len) + 1);
      end
      r_q.delete();
      @(negedge clk_i);
      n_vec++;
      if (r_valid_o !== 1'b0 || ar_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL r_done r_valid=%b ar_ready=%b want 0 1", r_valid_o, ar_ready_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      ar_send(4'h1, Base, 8'd3);
      rst_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         n_vec++;
         if ({r_valid_o, b_valid_o, aw_ready_o, ar_ready_o, w_ready_o} !== 5'b0) begin
            n_miss++;
            $display("FAIL rst_outputs r_v=%b b_v=%b aw_r=%b ar_r=%b w_r=%b want all 0",
                     r_valid_o, b_valid_o, aw_ready_o, ar_ready_o, w_ready_o);
         end
         @(posedge clk_i);
      end
      #1 rst_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         n_vec++;
         if ({aw_ready_o, ar_ready_o, r_valid_o, b_valid_o} !== 4'b1100) begin
            n_miss++;
            $display("FAIL rst_release aw_r=%b ar_r=%b r_v=%b b_v=%b want 1 1 0 0",
                     aw_ready_o, ar_ready_o, r_valid_o, b_valid_o);
         end
         @(posedge clk_i);
      end
      #1;
   endtask

   task automatic test_single_write();
      wd[0] = 64'h1122_3344_5566_7788;
      write_burst(4'h3, 64'h8000_0008, 8'd0, 8'hFF, 0, 2'b00);
      read_burst(4'h3, 64'h8000_0008, 8'd0, 1'b0, 2'b00);
   endtask

   task automatic test_partial_strobe();
      wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      write_burst(4'h2, 64'h8000_0008, 8'd0, 8'h0F, 0, 2'b00);
      n_vec++;
      if (model[1] !== 64'h1122_3344_AAAA_AAAA) begin
         n_miss++;
         $display("FAIL strobe_model got=%h want 1122334-4AAAAAAAA", model[1]);
      end
      read_burst(4'h2, 64'h8000_0008, 8'd0, 1'b0, 2'b00);
   endtask

   task automatic test_read_burst();
      wd[0] = 64'h0000_0000_0000_0A00;
      wd[1] = 64'h1111_0000_0000_0B01;
      wd[2] = 64'h2222_0000_0000_0C02;
      wd[3] = 64'h3333_0000_0000_0D03;
      write_burst(4'h7, Base, 8'd3, 8'hFF, 3, 2'b00);
      read_burst(4'h7, Base, 8'd3, 1'b1, 2'b00);
   endtask

   task automatic test_write_error();
      wd[0] = 64'hE000_0000_0000_0000;
      wd[1] = 64'hE111_1111_1111_1111;
      wd[2] = 64'hE222_2222_2222_2222;
      wd[3] = 64'hE333_3333_3333_3333;
      write_burst(4'h9, 64'h8000_0100, 8'd3, 8'hFF, 1, 2'b10);
      read_burst(4'h9, 64'h8000_0100, 8'd3, 1'b0, 2'b00);
   endtask

   task automatic test_range();
      wd[0] = 64'hDEAD_BEEF_0000_03FF;
      write_burst(4'h5, 64'h8000_1FF8, 8'd0, 8'hFF, 0, 2'b00);
      read_burst(4'h5, 64'h7FFF_FFF8, 8'd0, 1'b0, OorResp);
      wd[0] = 64'h0BAD_0BAD_0BAD_0BAD;
      write_burst(4'h6, 64'h7FFF_FFF8, 8'd0, 8'hFF, 0, OorResp);
      read_burst(4'h6, 64'h8000_1FF8, 8'd1, 1'b0, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_partial_strobe();
      test_read_burst();
      test_write_error();
      test_range();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 responder (slave) backed by a register-array SRAM.
- Terminates the core's AXI initiator port (ID 4b, addr 64b, data 64b) in core-level benches and small SoC configs: boot/DRAM model for the cached region at 0x8000_0000.
- Independent read and write FSMs.
- INCR bursts only. Full-width (8-byte) beats only.

Parameters:
- IdWidth, 4, AXI ID width.
- AddrWidth, 64, AXI address width.
- DataWidth, 64, beat width; fixed at 64 (strobe 8 bits).
- Depth, 1024, number of 64-bit words.
- BaseAddr, 64'h8000_0000, byte address of word 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write start byte address
- aw_len_i  in  8  beats minus one
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_data_i  in  64  write data
- w_strb_i  in  8  byte strobes
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  response ID
- b_resp_o  out  2  write response code
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read start byte address
- ar_len_i  in  8  beats minus one
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  IdWidth  read ID
- r_data_o  out  64  read data
- r_resp_o  out  2  read response code
- r_last_o  out  1  last read beat

Behaviour:
Reset and addressing:
- While rst_i is high, all outputs are 0 and both FSMs go to IDLE. The memory array is not reset.
- Word index = ((addr - BaseAddr) >> 3) mod Depth. Addr bits [2:0] are ignored. The index increments per beat and wraps modulo Depth.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: aw_ready_o=1. On the AW handshake, latch id, index and len; beat counter = 0; go to W_DATA.
- W_DATA: w_ready_o=1. Each W handshake writes the bytes enabled by w_strb_i to mem[index], then increments index and counter.
- On the beat where counter==len, go to W_RESP.
- Protocol error: w_last_i=1 before the final beat, or 0 on the final beat, sets b_resp 2'b10 (SLVERR). Data is still written, and the burst length is governed by len only.
- W_RESP: b_valid_o=1 with b_id_o = latched id and b_resp_o = 00 or error code, held stable until b_ready_i. Then return to W_IDLE.
- AW is accepted only in W_IDLE, so there is no write overlap.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: ar_ready_o=1. On the AR handshake, latch id, index and len; go to R_DATA.
- r_data_o is registered from mem[index]. r_valid_o rises in the cycle after the AR handshake.
- r_id_o, r_data_o, r_resp_o and r_last_o stay stable while r_valid_o=1 and r_ready_i=0.
- On each R handshake that is not the last, the next beat is loaded on the same edge, so back-to-back beats are possible with r_ready_i held high.
- r_last_o=1 only when counter==len.
- After the last handshake: r_valid_o=0 and return to R_IDLE; ar_ready_o=1 the next cycle.

Same-word collision:
- A read load and a write to the same word on the same edge return the pre-write data.

Optional Feature:
- AXI_SRAM_DECERR_EN defined: the AW/AR start address is range-checked against [BaseAddr, BaseAddr+Depth*8).
  - Out-of-range write: the whole burst is accepted, the memory is not modified, b_resp 2'b11.
  - Out-of-range read: all beats carry r_data 0 and r_resp 2'b11.
  - In-range bursts that run past the end wrap modulo Depth with OKAY.
- Undefined: no range check, the address is taken modulo Depth, and responses are always OKAY apart from the w_last SLVERR.

Test Plan:
- Reset: hold rst_i for 3 cycles mid-read-burst, then release -> r_valid_o=0, b_valid_o=0 during reset; aw_ready_o=ar_ready_o=1 the first cycle after release; the old burst is not resumed.
- Single write: aw_addr 0x8000_0008, id 3, data 0x1122334455667788, strb 0xFF, w_last 1 -> b_id 3, b_resp 00. Read of the same address with len 0 -> same data, r_last 1, r_id 3, r_valid one cycle after AR handshake.
- Partial strobe: write data 0xAAAAAAAAAAAAAAAA, strb 0x0F to 0x8000_0008 -> read returns 0x11223344AAAAAAAA.
- Read burst: 4 words written, then a len-3 read at 0x8000_0000 with r_ready_i toggling each cycle -> exactly 4 beats in address order, payload stable while stalled, r_last only on beat 4.
- Write protocol error: len 3 with w_last_i=1 on beat 1 -> 4 beats accepted, b_resp 2'b10.
- Range: read at 0x7FFF_FFF8, len 0 -> with AXI_SRAM_DECERR_EN, r_resp 2'b11 and data 0; without it, returns mem[Depth-1] with resp 00.
